// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types for the IF/MEM single-port memory arbiter.
//               Holds the arbiter FSM state enum and the grant-select enum.
//               The bus command encodings are normally provided by
//               sys_defs.vh. The guarded fallbacks below apply only when
//               that header has not been included first, so the shared
//               encodings are never overridden.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef BUS_NONE
`define BUS_NONE  2'h0
`endif
`ifndef BUS_LOAD
`define BUS_LOAD  2'h1
`endif
`ifndef BUS_STORE
`define BUS_STORE 2'h2
`endif

package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_IF   = 2'd1,
        GRANT_DM   = 2'd2
    } grant_e;

endpackage

`default_nettype wire

// File: rtl/pipeline_mem_arbiter_if.sv
// ============================================================================
// Module      : pipeline_mem_arbiter_if
// Description : Unified memory bus between the arbiter (master) and the
//               memory (slave).
//   bus_command  master->slave  2       command (NONE/LOAD/STORE)
//   bus_addr     master->slave  ADDR_W  address, held until bus_ack
//   bus_wdata    master->slave  DATA_W  store data, held until bus_ack
//   bus_rdata    slave->master  DATA_W  read data, valid with bus_ack
//   bus_ack      slave->master  1       current command completes this cycle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    logic [1:0]        bus_command;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;

    modport master (
        output bus_command,
        output bus_addr,
        output bus_wdata,
        input  bus_rdata,
        input  bus_ack
    );

    modport slave (
        input  bus_command,
        input  bus_addr,
        input  bus_wdata,
        output bus_rdata,
        output bus_ack
    );

endinterface

`default_nettype wire

// File: rtl/mem_arb_prio.sv
// ============================================================================
// Module      : mem_arb_prio
// Description : Combinational fetch-vs-data priority pick. Data wins by
//               default. With MEM_ARB_FAIRNESS_EN defined, a saturating
//               counter of consecutive data grants made while a fetch is
//               pending forces one fetch grant once it reaches
//               MAX_DATA_BURST.
//   clk, rst     clock / async active-high reset (counter only)
//   if_req_i     fetch request
//   dm_req_i     data request (command != NONE)
//   arb_en_i     arbiter is in IDLE; a non-NONE grant is taken this cycle
//   grant_o      selected requester
// Macro       : MEM_ARB_FAIRNESS_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_BURST = 4
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic if_req_i,
    input  wire logic dm_req_i,
    input  wire logic arb_en_i,
    output grant_e    grant_o
);

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int               CNT_W     = $clog2(MAX_DATA_BURST + 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(MAX_DATA_BURST);

    logic [CNT_W-1:0] burst_cnt_q;
    logic [CNT_W-1:0] burst_cnt_d;
    logic             w_force_if;

    // Override only matters while a fetch is actually waiting.
    assign w_force_if = if_req_i && (burst_cnt_q >= C_CNT_MAX);

    always_comb begin
        grant_o = GRANT_NONE;
        if (dm_req_i && !w_force_if) begin
            grant_o = GRANT_DM;
        end else if (if_req_i) begin
            grant_o = GRANT_IF;
        end
    end

    // A data grant with no fetch waiting breaks the run of starved fetches.
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (arb_en_i) begin
            if (grant_o == GRANT_IF) begin
                burst_cnt_d = '0;
            end else if (grant_o == GRANT_DM) begin
                if (!if_req_i) begin
                    burst_cnt_d = '0;
                end else if (burst_cnt_q < C_CNT_MAX) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst, arb_en_i};

    always_comb begin
        grant_o = GRANT_NONE;
        if (dm_req_i) begin
            grant_o = GRANT_DM;
        end else if (if_req_i) begin
            grant_o = GRANT_IF;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/pipeline_mem_arbiter.sv
// ============================================================================
// Module      : pipeline_mem_arbiter
// Description : Single-port memory arbiter between the IF and MEM stages.
//               Grants one requester per bus transaction, holds the bus
//               registers stable until bus_ack, returns data with a one-cycle
//               done pulse and drives the pipeline stall outputs.
//   clk, rst              clock / async active-high reset
//   if_req_i, if_addr_i   fetch request and PC
//   if_rdata_o, if_done_o fetched instruction, completion pulse
//   if_stall_o            if_req_i && !if_done_o
//   dm_command_i          NONE/LOAD/STORE from MEM stage
//   dm_addr_i, dm_wdata_i data address and store data
//   dm_rdata_o, dm_done_o load data, completion pulse
//   dm_stall_o            data request && !dm_done_o
//   bus                   memory bus (master modport)
// Macro       : MEM_ARB_FAIRNESS_EN (fetch fairness after MAX_DATA_BURST)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_DATA_BURST = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              if_req_i,
    input  wire logic [ADDR_W-1:0] if_addr_i,
    output logic      [DATA_W-1:0] if_rdata_o,
    output logic                   if_done_o,
    output logic                   if_stall_o,
    input  wire logic [1:0]        dm_command_i,
    input  wire logic [ADDR_W-1:0] dm_addr_i,
    input  wire logic [DATA_W-1:0] dm_wdata_i,
    output logic      [DATA_W-1:0] dm_rdata_o,
    output logic                   dm_done_o,
    output logic                   dm_stall_o,
    pipeline_mem_arbiter_if.master bus
);

    arb_state_e        state_q, state_d;
    logic [1:0]        bus_cmd_q, bus_cmd_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              w_dm_req;
    grant_e            w_grant;

    assign w_dm_req = (dm_command_i != `BUS_NONE);

    mem_arb_prio #(
        .MAX_DATA_BURST (MAX_DATA_BURST)
    ) u_prio (
        .clk      (clk),
        .rst      (rst),
        .if_req_i (if_req_i),
        .dm_req_i (w_dm_req),
        .arb_en_i (state_q == IDLE),
        .grant_o  (w_grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_cmd_q   <= `BUS_NONE;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            bus_cmd_q   <= bus_cmd_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
        end
    end

    // Requester inputs are only looked at in IDLE; in BUSY the bus registers
    // simply hold until the memory acknowledges.
    always_comb begin
        state_d     = state_q;
        bus_cmd_d   = bus_cmd_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_done_o   = 1'b0;
        dm_done_o   = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_grant == GRANT_DM) begin
                    state_d     = DM_BUSY;
                    bus_cmd_d   = dm_command_i;
                    bus_addr_d  = dm_addr_i;
                    bus_wdata_d = dm_wdata_i;
                end else if (w_grant == GRANT_IF) begin
                    state_d    = IF_BUSY;
                    bus_cmd_d  = `BUS_LOAD;
                    bus_addr_d = if_addr_i;
                end
            end
            IF_BUSY: begin
                if (bus.bus_ack) begin
                    if_done_o = 1'b1;
                    state_d   = IDLE;
                    bus_cmd_d = `BUS_NONE;
                end
            end
            DM_BUSY: begin
                if (bus.bus_ack) begin
                    dm_done_o = 1'b1;
                    state_d   = IDLE;
                    bus_cmd_d = `BUS_NONE;
                end
            end
            default: begin
                state_d   = IDLE;
                bus_cmd_d = `BUS_NONE;
            end
        endcase
    end

    assign bus.bus_command = bus_cmd_q;
    assign bus.bus_addr    = bus_addr_q;
    assign bus.bus_wdata   = bus_wdata_q;

    // Read data is only meaningful alongside the matching done pulse.
    assign if_rdata_o = bus.bus_rdata;
    assign dm_rdata_o = bus.bus_rdata;

    assign if_stall_o = if_req_i && !if_done_o;
    assign dm_stall_o = w_dm_req && !dm_done_o;

endmodule

`default_nettype wire

// File: doc/pipeline_mem_arbiter.md
# pipeline_mem_arbiter

Single-port memory arbiter/sequencer between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage pipeline. Both stages share one unified memory bus with variable response latency. The block grants one requester per bus transaction, holds bus signals stable until acknowledge, returns data and a done pulse to the granted requester, and drives the stall signals that freeze the pipeline registers while a stage waits.

## Interface
- `MAX_DATA_BURST`, default 4: consecutive data grants allowed before a pending fetch is forced in (only with the fairness macro).
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; asynchronous, active-high.
- `if_req` in 1: fetch request.
- `if_addr` in ADDR_W: fetch address (PC).
- `if_rdata` out DATA_W: fetched instruction; valid when `if_done`.
- `if_done` out 1: one-cycle fetch-complete pulse.
- `if_stall` out 1: `if_req && !if_done`.
- `dm_command` in 2: `BUS_NONE` / `BUS_LOAD` / `BUS_STORE` from MEM stage.
- `dm_addr` in ADDR_W: data address.
- `dm_wdata` in DATA_W: store data.
- `dm_rdata` out DATA_W: load data; valid when `dm_done`.
- `dm_done` out 1: one-cycle data-complete pulse (load or store).
- `dm_stall` out 1: `(dm_command != BUS_NONE) && !dm_done`.
- `bus_command` out 2: command to memory.
- `bus_addr` out ADDR_W: registered bus address.
- `bus_wdata` out DATA_W: registered store data.
- `bus_rdata` in DATA_W: memory read data.
- `bus_ack` in 1: memory completes the current command this cycle.

## Operation
- FSM states:
  - `IDLE`: no bus command.
  - `IF_BUSY`: fetch in flight.
  - `DM_BUSY`: data access in flight.
- In `IDLE`, arbitration between requests sampled this cycle:
  - data request wins over fetch, because MEM holds the older instruction;
  - the winner's command, address and data are captured into bus registers;
  - the FSM moves to the matching BUSY state.
- In BUSY, `bus_command`, `bus_addr` and `bus_wdata` are held constant. Requester inputs are ignored until `bus_ack`.
- On `bus_ack` in BUSY:
  - `bus_rdata` passes combinationally to `if_rdata` or `dm_rdata`;
  - the matching done output pulses high for that cycle;
  - the FSM returns to `IDLE` next cycle.
- A store completes on ack. `dm_rdata` is don't-care on a store, and the bench must not check it.
- `bus_ack` outside BUSY is ignored.
- A request dropped by the requester while BUSY does not abort the transaction. Its done pulse still occurs and the requester ignores it.
- Reset, at any time including mid-transaction:
  - FSM goes to `IDLE`;
  - `bus_command` = `BUS_NONE`;
  - `bus_addr` and `bus_wdata` = 0;
  - `if_done` and `dm_done` = 0;
  - burst counter = 0;
  - an in-flight memory response after reset release is ignored.
- Stall outputs are combinational and equal 0 whenever there is no request.

## Timing
- Request seen in `IDLE` at cycle N: `bus_command` is valid from cycle N+1.
- Ack at cycle M ≥ N+1: done and data at cycle M, FSM in `IDLE` at M+1.
- Next grant can be made at M+1, with its command on the bus at M+2.
- Minimum transaction time is therefore 2 cycles (zero-wait memory acks at N+1), with one `IDLE` cycle between back-to-back transactions.
- Simultaneous fetch and data request: data is served first, and fetch follows at the earliest 2 cycles after the data ack.
- `bus_command` is `BUS_NONE` in `IDLE` and `BUS_LOAD` in `IF_BUSY`.

## Configuration
- `MEM_ARB_FAIRNESS_EN` defined:
  - a saturating counter counts consecutive data grants made while `if_req` is pending;
  - when it reaches `MAX_DATA_BURST`, the next `IDLE` arbitration grants fetch even if data is requesting;
  - the counter clears on any fetch grant.
- `MEM_ARB_FAIRNESS_EN` undefined: strict data priority and no counter logic.

## Structure
- Package `mem_arb_pkg` holds the FSM state enum (`IDLE`, `IF_BUSY`, `DM_BUSY`) and the grant-select enum.
- Bus command encodings (`BUS_NONE`, `BUS_LOAD`, `BUS_STORE`) come from `sys_defs.vh` and are not redefined.
- One sub-module, `mem_arb_prio`:
  - combinational priority pick of fetch vs data;
  - fairness counter and override, inside the macro guard.
- The FSM and bus registers live in `pipeline_mem_arbiter`.

## Test plan
- Reset mid-`DM_BUSY`:
  - `rst` pulse → next cycle `bus_command`=`BUS_NONE`, FSM in `IDLE`, no done pulse;
  - a late `bus_ack` is ignored.
- Lone fetch of address 0x100, ack at first BUSY cycle, `bus_rdata`=0x00000013 → `if_done` pulse with `if_rdata`=0x00000013; `if_stall` high exactly 1 cycle before done.
- Simultaneous `if_req` (0x104) and `BUS_LOAD` (0x2000), 3-cycle memory:
  - data is served first, `dm_done` at cycle 3;
  - fetch is issued at cycle 5, `if_done` at cycle 7.
- Store `BUS_STORE` to 0x2004, data 0xDEADBEEF, ack after 4 cycles → `bus_addr` and `bus_wdata` stable for all 4 cycles; `dm_done` pulses once.
- Fairness on, `MAX_DATA_BURST`=4, continuous data requests plus a pending fetch → after 4 data grants the 5th grant is fetch; with the macro off, fetch is never granted until data requests drop.
- Spurious `bus_ack` while `IDLE` → no done pulse, FSM stays `IDLE`.
